// File: rtl/legv8_control_unit.sv
// legv8_control_unit
// Multicycle control unit for the LEGv8 datapath. It latches the instruction
// from the instruction ROM in FETCH, decodes it from the instruction register,
// and runs it through one or two execute states (EX0, EX1). Each cycle it
// drives a 32-bit control word for the datapath and the decoded immediate K.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   instruction  ROM output addressed by PC
//   status       [3:0] = {V,C,N,Z} live ALU flags, [4] = registered Z
//   ir_load      high in FETCH; the IR captures instruction at that edge
//   controlword  [31]=0 [30:29]Psel [28:24]DA [23:19]SA [18:14]SB [13:9]Fsel
//                [8]regW [7]ramW [6]EN_MEM [5]EN_ALU [4]EN_B [3]EN_PC
//                [2]Bsel [1]PCsel [0]SL
//   K            decoded immediate, zero in FETCH and while in reset
//   illegal      sticky flag, set when an undecodable opcode reaches EX0
module legv8_control_unit #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned LINK_REG = 30
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [31:0]     instruction,
    input  logic [4:0]      status,
    output logic            ir_load,
    output logic [31:0]     controlword,
    output logic [XLEN-1:0] K,
    output logic            illegal
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EX0   = 2'd1;
    localparam logic [1:0] S_EX1   = 2'd2;

    localparam logic [1:0] PSEL_HOLD = 2'b00;
    localparam logic [1:0] PSEL_NEXT = 2'b01;
    localparam logic [1:0] PSEL_REL  = 2'b10;
    localparam logic [1:0] PSEL_BUS  = 2'b11;

    localparam logic [4:0] FSEL_AND = 5'b00000;
    localparam logic [4:0] FSEL_ORR = 5'b00100;
    localparam logic [4:0] FSEL_ADD = 5'b01000;
    localparam logic [4:0] FSEL_SUB = 5'b01001;

    localparam logic [4:0] OP_ADD     = 5'd0;
    localparam logic [4:0] OP_SUB     = 5'd1;
    localparam logic [4:0] OP_AND     = 5'd2;
    localparam logic [4:0] OP_ORR     = 5'd3;
    localparam logic [4:0] OP_ADDS    = 5'd4;
    localparam logic [4:0] OP_SUBS    = 5'd5;
    localparam logic [4:0] OP_LDUR    = 5'd6;
    localparam logic [4:0] OP_STUR    = 5'd7;
    localparam logic [4:0] OP_BR      = 5'd8;
    localparam logic [4:0] OP_ADDI    = 5'd9;
    localparam logic [4:0] OP_SUBI    = 5'd10;
    localparam logic [4:0] OP_MOVZ    = 5'd11;
    localparam logic [4:0] OP_CBZ     = 5'd12;
    localparam logic [4:0] OP_CBNZ    = 5'd13;
    localparam logic [4:0] OP_B       = 5'd14;
    localparam logic [4:0] OP_BL      = 5'd15;
    localparam logic [4:0] OP_ILLEGAL = 5'd16;

    localparam logic [4:0] ZERO_REG = 5'd31;
    localparam logic [4:0] LINK_DA  = 5'(LINK_REG);

    logic [1:0]      state;
    logic [31:0]     ir;
    logic [4:0]      op;
    logic            active;
    logic            in_ex1;
    logic [XLEN-1:0] k_dec;

    logic [1:0] psel;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fsel;
    logic       reg_w;
    logic       ram_w;
    logic       en_mem;
    logic       en_alu;
    logic       en_b;
    logic       en_pc;
    logic       b_sel;
    logic       pc_sel;
    logic       set_flags;

    // Only the live Z flag steers control; the other flags belong to the datapath.
    logic unused_status;
    assign unused_status = ^status[4:1];

    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    assign rd = ir[4:0];
    assign rn = ir[9:5];
    assign rm = ir[20:16];

    // Opcodes are checked longest first so that a short opcode never shadows
    // a longer one that shares its leading bits.
    always_comb begin
        op = OP_ILLEGAL;
        if      (ir[31:21] == 11'b10001011000) op = OP_ADD;
        else if (ir[31:21] == 11'b11001011000) op = OP_SUB;
        else if (ir[31:21] == 11'b10001010000) op = OP_AND;
        else if (ir[31:21] == 11'b10101010000) op = OP_ORR;
        else if (ir[31:21] == 11'b10101011000) op = OP_ADDS;
        else if (ir[31:21] == 11'b11101011000) op = OP_SUBS;
        else if (ir[31:21] == 11'b11111000010) op = OP_LDUR;
        else if (ir[31:21] == 11'b11111000000) op = OP_STUR;
        else if (ir[31:21] == 11'b11010110000) op = OP_BR;
        else if (ir[31:22] == 10'b1001000100)  op = OP_ADDI;
        else if (ir[31:22] == 10'b1101000100)  op = OP_SUBI;
        else if (ir[31:23] == 9'b110100101)    op = OP_MOVZ;
        else if (ir[31:24] == 8'b10110100)     op = OP_CBZ;
        else if (ir[31:24] == 8'b10110101)     op = OP_CBNZ;
        else if (ir[31:26] == 6'b000101)       op = OP_B;
        else if (ir[31:26] == 6'b100101)       op = OP_BL;
    end

    // Immediate decode depends only on the latched instruction, so K stays
    // stable across both execute states of LDUR and BL.
    always_comb begin
        k_dec = '0;
        case (op)
            OP_ADDI, OP_SUBI: k_dec = XLEN'(ir[21:10]);
            OP_MOVZ:          k_dec = XLEN'(ir[20:5]) << {ir[22:21], 4'b0000};
            OP_LDUR, OP_STUR: k_dec = XLEN'($signed(ir[20:12]));
            OP_CBZ, OP_CBNZ:  k_dec = XLEN'($signed({ir[23:5], 2'b00}));
            OP_B, OP_BL:      k_dec = XLEN'($signed({ir[25:0], 2'b00}));
            default:          k_dec = '0;
        endcase
    end

    // Reset abandons whatever instruction was in flight; the sticky illegal
    // flag is only cleared here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= instruction;
                    state <= S_EX0;
                end
                S_EX0: begin
                    if (op == OP_ILLEGAL) begin
                        illegal <= 1'b1;
                    end
                    state <= (op == OP_LDUR || op == OP_BL) ? S_EX1 : S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Outputs are gated by reset_n so they drop to zero the moment reset is
    // asserted rather than at the next edge.
    assign active  = reset_n && (state == S_EX0 || state == S_EX1);
    assign in_ex1  = (state == S_EX1);
    assign ir_load = reset_n && (state == S_FETCH);
    assign K       = active ? k_dec : '0;

    // PC updates only happen in the final execute state, so every branch
    // target is relative to the branch's own address.
    always_comb begin
        psel      = PSEL_HOLD;
        da        = '0;
        sa        = '0;
        sb        = '0;
        fsel      = FSEL_AND;
        reg_w     = 1'b0;
        ram_w     = 1'b0;
        en_mem    = 1'b0;
        en_alu    = 1'b0;
        en_b      = 1'b0;
        en_pc     = 1'b0;
        b_sel     = 1'b0;
        pc_sel    = 1'b0;
        set_flags = 1'b0;
        if (active) begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS: begin
                    sa     = rn;
                    sb     = rm;
                    da     = rd;
                    en_alu = 1'b1;
                    reg_w  = 1'b1;
                    psel   = PSEL_NEXT;
                    case (op)
                        OP_SUB, OP_SUBS: fsel = FSEL_SUB;
                        OP_AND:          fsel = FSEL_AND;
                        OP_ORR:          fsel = FSEL_ORR;
                        default:         fsel = FSEL_ADD;
                    endcase
                    set_flags = (op == OP_ADDS || op == OP_SUBS);
                end
                OP_ADDI, OP_SUBI: begin
                    sa     = rn;
                    da     = rd;
                    b_sel  = 1'b1;
                    fsel   = (op == OP_SUBI) ? FSEL_SUB : FSEL_ADD;
                    en_alu = 1'b1;
                    reg_w  = 1'b1;
                    psel   = PSEL_NEXT;
                end
                OP_MOVZ: begin
                    da    = rd;
                    b_sel = 1'b1;
                    en_b  = 1'b1;
                    reg_w = 1'b1;
                    psel  = PSEL_NEXT;
                end
                OP_LDUR: begin
                    // EX0 only presents the address; the load lands in EX1.
                    sa    = rn;
                    b_sel = 1'b1;
                    fsel  = FSEL_ADD;
                    if (in_ex1) begin
                        en_mem = 1'b1;
                        reg_w  = 1'b1;
                        da     = rd;
                        psel   = PSEL_NEXT;
                    end else begin
                        psel   = PSEL_HOLD;
                    end
                end
                OP_STUR: begin
                    // Store data comes from the B port ahead of the Bsel mux.
                    sa    = rn;
                    sb    = rd;
                    b_sel = 1'b1;
                    fsel  = FSEL_ADD;
                    ram_w = 1'b1;
                    psel  = PSEL_NEXT;
                end
                OP_CBZ, OP_CBNZ: begin
                    sa   = rd;
                    sb   = ZERO_REG;
                    fsel = FSEL_ADD;
                    psel = ((op == OP_CBZ) == status[0]) ? PSEL_REL : PSEL_NEXT;
                end
                OP_B: begin
                    psel = PSEL_REL;
                end
                OP_BL: begin
                    // Link is written while PC still points at the BL itself.
                    if (in_ex1) begin
                        psel = PSEL_REL;
                    end else begin
                        da    = LINK_DA;
                        en_pc = 1'b1;
                        reg_w = 1'b1;
                        psel  = PSEL_HOLD;
                    end
                end
                OP_BR: begin
                    sa     = rn;
                    sb     = ZERO_REG;
                    fsel   = FSEL_ORR;
                    en_alu = 1'b1;
                    pc_sel = 1'b1;
                    psel   = PSEL_BUS;
                end
                default: begin
                    psel = PSEL_NEXT;
                end
            endcase
        end
    end

    assign controlword = {1'b0, psel, da, sa, sb, fsel, reg_w, ram_w, en_mem,
                          en_alu, en_b, en_pc, b_sel, pc_sel, set_flags};

endmodule

// File: tb/tb_legv8_control_unit.sv
// tb_legv8_control_unit
// Self-checking bench for legv8_control_unit. A behavioural model tracks which
// instruction is executing and in which cycle of it, and derives the control
// word and K from the LEGv8 instruction semantics. A compare process checks the
// DUT against the model every falling edge; directed scenarios add literal
// expectations, then a randomized run with occasional resets follows.
module tb_legv8_control_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instruction = '0;
    logic [4:0]  status = '0;
    logic        irLoad;
    logic [31:0] controlword;
    logic [63:0] k;
    logic        illegal;

    legv8_control_unit #(.XLEN(64), .LINK_REG(30)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instruction (instruction),
        .status      (status),
        .ir_load     (irLoad),
        .controlword (controlword),
        .K           (k),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    localparam int C_ADD = 0, C_SUB = 1, C_AND = 2, C_ORR = 3, C_ADDS = 4, C_SUBS = 5;
    localparam int C_LDUR = 6, C_STUR = 7, C_BR = 8, C_ADDI = 9, C_SUBI = 10, C_MOVZ = 11;
    localparam int C_CBZ = 12, C_CBNZ = 13, C_B = 14, C_BL = 15, C_ILL = 16;

    int checkCount = 0;
    int passCount = 0;
    logic checkEnable = 1'b0;

    logic [31:0] expCw = '0;
    logic [63:0] expK = '0;
    logic        expIrLoad = 1'b0;
    logic        expIllegal = 1'b0;

    // Model state: instruction being executed, cycle within it (0 = fetch).
    logic [31:0] mIr = '0;
    int          mPhase = 0;
    logic        mIllegal = 1'b0;

    function automatic int opLen(input int c);
        case (c)
            C_ADDI, C_SUBI: return 10;
            C_MOVZ:         return 9;
            C_CBZ, C_CBNZ:  return 8;
            C_B, C_BL:      return 6;
            default:        return 11;
        endcase
    endfunction

    function automatic logic [31:0] opPat(input int c);
        case (c)
            C_ADD:   return 32'b10001011000;
            C_SUB:   return 32'b11001011000;
            C_AND:   return 32'b10001010000;
            C_ORR:   return 32'b10101010000;
            C_ADDS:  return 32'b10101011000;
            C_SUBS:  return 32'b11101011000;
            C_LDUR:  return 32'b11111000010;
            C_STUR:  return 32'b11111000000;
            C_BR:    return 32'b11010110000;
            C_ADDI:  return 32'b1001000100;
            C_SUBI:  return 32'b1101000100;
            C_MOVZ:  return 32'b110100101;
            C_CBZ:   return 32'b10110100;
            C_CBNZ:  return 32'b10110101;
            C_B:     return 32'b000101;
            default: return 32'b100101;
        endcase
    endfunction

    function automatic int classify(input logic [31:0] ins);
        for (int len = 11; len >= 6; len--) begin
            for (int c = 0; c < 16; c++) begin
                if (opLen(c) == len && (ins >> (32 - len)) == opPat(c)) return c;
            end
        end
        return C_ILL;
    endfunction

    function automatic longint sext(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic int execLen(input int c);
        return (c == C_LDUR || c == C_BL) ? 2 : 1;
    endfunction

    // Expected outputs of one execute cycle, from the instruction semantics.
    task automatic modelControl(input logic [31:0] ins, input int phase, input logic [4:0] st,
                                output logic [31:0] cw, output logic [63:0] kv);
        int cls;
        int psel, da, sa, sb, fsel;
        int regW, ramW, enMem, enAlu, enB, enPc, bSel, pcSel, sl;
        longint kk;
        int rd, rn, rm;
        cls = classify(ins);
        rd = int'(ins[4:0]);
        rn = int'(ins[9:5]);
        rm = int'(ins[20:16]);
        psel = 0; da = 0; sa = 0; sb = 0; fsel = 0;
        regW = 0; ramW = 0; enMem = 0; enAlu = 0; enB = 0; enPc = 0; bSel = 0; pcSel = 0; sl = 0;
        kk = 0;
        case (cls)
            C_ADD, C_SUB, C_AND, C_ORR, C_ADDS, C_SUBS: begin
                sa = rn; sb = rm; da = rd; enAlu = 1; regW = 1; psel = 1;
                if (cls == C_SUB || cls == C_SUBS) fsel = 9;
                else if (cls == C_ORR) fsel = 4;
                else if (cls == C_AND) fsel = 0;
                else fsel = 8;
                sl = (cls == C_ADDS || cls == C_SUBS) ? 1 : 0;
            end
            C_ADDI, C_SUBI: begin
                sa = rn; da = rd; bSel = 1; enAlu = 1; regW = 1; psel = 1;
                fsel = (cls == C_SUBI) ? 9 : 8;
                kk = longint'(ins[21:10]);
            end
            C_MOVZ: begin
                da = rd; bSel = 1; enB = 1; regW = 1; psel = 1;
                kk = longint'(ins[20:5]) * (longint'(1) << (16 * int'(ins[22:21])));
            end
            C_LDUR: begin
                sa = rn; bSel = 1; fsel = 8;
                if (phase == 2) begin
                    enMem = 1; regW = 1; da = rd; psel = 1;
                end
                kk = sext(longint'(ins[20:12]), 9);
            end
            C_STUR: begin
                sa = rn; sb = rd; bSel = 1; fsel = 8; ramW = 1; psel = 1;
                kk = sext(longint'(ins[20:12]), 9);
            end
            C_CBZ, C_CBNZ: begin
                sa = rd; sb = 31; fsel = 8;
                if (cls == C_CBZ) psel = (st[0] == 1'b1) ? 2 : 1;
                else psel = (st[0] == 1'b0) ? 2 : 1;
                kk = sext(longint'(ins[23:5]), 19) * 4;
            end
            C_B: begin
                psel = 2;
                kk = sext(longint'(ins[25:0]), 26) * 4;
            end
            C_BL: begin
                if (phase == 1) begin
                    da = 30; enPc = 1; regW = 1; psel = 0;
                end else begin
                    psel = 2;
                end
                kk = sext(longint'(ins[25:0]), 26) * 4;
            end
            C_BR: begin
                sa = rn; sb = 31; fsel = 4; enAlu = 1; pcSel = 1; psel = 3;
            end
            default: begin
                psel = 1;
            end
        endcase
        cw = {1'b0, 2'(psel), 5'(da), 5'(sa), 5'(sb), 5'(fsel), 1'(regW), 1'(ramW),
              1'(enMem), 1'(enAlu), 1'(enB), 1'(enPc), 1'(bSel), 1'(pcSel), 1'(sl)};
        kv = 64'(kk);
    endtask

    task automatic computeExp();
        if (!reset_n) begin
            expCw = '0; expK = '0; expIrLoad = 1'b0; expIllegal = 1'b0;
        end else if (mPhase == 0) begin
            expCw = '0; expK = '0; expIrLoad = 1'b1; expIllegal = mIllegal;
        end else begin
            modelControl(mIr, mPhase, status, expCw, expK);
            expIrLoad = 1'b0;
            expIllegal = mIllegal;
        end
    endtask

    // Model reaction to a rising edge with reset released.
    task automatic advanceModel();
        int cls;
        if (mPhase == 0) begin
            mIr = instruction;
            mPhase = 1;
        end else begin
            cls = classify(mIr);
            if (mPhase == 1 && cls == C_ILL) mIllegal = 1'b1;
            if (mPhase < execLen(cls)) mPhase = mPhase + 1;
            else mPhase = 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // One clock cycle: inputs change just after the rising edge and the
    // task returns on the falling edge, where outputs are sampled.
    task automatic applyStimulus(input logic [31:0] ins, input logic [4:0] st);
        @(posedge clock);
        #1;
        if (reset_n) advanceModel();
        instruction = ins;
        status = st;
        computeExp();
        @(negedge clock);
    endtask

    task automatic releaseReset(input logic [31:0] nextIns);
        instruction = nextIns;
        #1;
        reset_n = 1'b1;
        mPhase = 0;
        mIllegal = 1'b0;
        computeExp();
        #1;
        checkOutput("release.ir_load", 64'(irLoad), 64'd1);
    endtask

    task automatic doReset(input logic [31:0] nextIns);
        #1;
        reset_n = 1'b0;
        mPhase = 0;
        mIllegal = 1'b0;
        computeExp();
        #1;
        checkOutput("reset.controlword", 64'(controlword), 64'd0);
        checkOutput("reset.ir_load", 64'(irLoad), 64'd0);
        checkOutput("reset.k", k, 64'd0);
        @(negedge clock);
        releaseReset(nextIns);
    endtask

    function automatic logic [31:0] randInstr();
        int pick;
        logic [31:0] r;
        logic [31:0] mask;
        pick = $urandom_range(0, 19);
        r = $urandom;
        if (pick < 16) begin
            mask = 32'hFFFF_FFFF << (32 - opLen(pick));
            r = (r & ~mask) | (opPat(pick) << (32 - opLen(pick)));
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (checkEnable) begin
            checkOutput("cycle.controlword", 64'(controlword), 64'(expCw));
            checkOutput("cycle.k", k, expK);
            checkOutput("cycle.ir_load", 64'(irLoad), 64'(expIrLoad));
            checkOutput("cycle.illegal", 64'(illegal), 64'(expIllegal));
        end
    end

    logic [31:0] addiIns;
    logic [31:0] ldurIns;
    logic [31:0] cbzIns;
    logic [31:0] bIns;
    logic [31:0] movz0Ins;
    logic [31:0] movz1Ins;

    initial begin
        addiIns  = 32'h910193E4;
        ldurIns  = {11'b11111000010, 9'd0, 2'b00, 5'd8, 5'd10};
        cbzIns   = {8'b10110100, 19'd6, 5'd4};
        bIns     = 32'h17FFFFF9;
        movz0Ins = {9'b110100101, 2'd0, 16'd1200, 5'd9};
        movz1Ins = {9'b110100101, 2'd1, 16'd1200, 5'd9};

        $display("[TB] start");
        reset_n = 1'b0;
        instruction = addiIns;
        computeExp();
        checkEnable = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("por.controlword", 64'(controlword), 64'd0);
        checkOutput("por.k", k, 64'd0);
        checkOutput("por.ir_load", 64'(irLoad), 64'd0);
        checkOutput("por.illegal", 64'(illegal), 64'd0);
        releaseReset(addiIns);

        // ADDI X4, XZR, #100
        applyStimulus($urandom, 5'd0);
        checkOutput("addi.controlword", 64'(controlword), 64'h24F8_1124);
        checkOutput("addi.psel", 64'(controlword[30:29]), 64'd1);
        checkOutput("addi.da", 64'(controlword[28:24]), 64'd4);
        checkOutput("addi.sa", 64'(controlword[23:19]), 64'd31);
        checkOutput("addi.fsel", 64'(controlword[13:9]), 64'b01000);
        checkOutput("addi.k", k, 64'd100);
        applyStimulus(ldurIns, 5'd0);
        checkOutput("addi.refetch", 64'(irLoad), 64'd1);

        // LDUR X10, [X8, #0]
        applyStimulus($urandom, 5'd0);
        checkOutput("ldur0.sa", 64'(controlword[23:19]), 64'd8);
        checkOutput("ldur0.bsel", 64'(controlword[2]), 64'd1);
        checkOutput("ldur0.psel", 64'(controlword[30:29]), 64'd0);
        checkOutput("ldur0.regw", 64'(controlword[8]), 64'd0);
        applyStimulus($urandom, 5'd0);
        checkOutput("ldur1.enmem", 64'(controlword[6]), 64'd1);
        checkOutput("ldur1.regw", 64'(controlword[8]), 64'd1);
        checkOutput("ldur1.da", 64'(controlword[28:24]), 64'd10);
        checkOutput("ldur1.psel", 64'(controlword[30:29]), 64'd1);
        applyStimulus(cbzIns, 5'd0);
        checkOutput("ldur.refetch", 64'(irLoad), 64'd1);

        // CBZ X4, #6 taken, then not taken
        applyStimulus($urandom, 5'b00001);
        checkOutput("cbz_taken.psel", 64'(controlword[30:29]), 64'd2);
        checkOutput("cbz_taken.k", k, 64'd24);
        applyStimulus(cbzIns, 5'd0);
        applyStimulus($urandom, 5'b11110);
        checkOutput("cbz_fall.psel", 64'(controlword[30:29]), 64'd1);
        checkOutput("cbz_fall.k", k, 64'd24);

        // B -7
        applyStimulus(bIns, 5'd0);
        applyStimulus($urandom, 5'($urandom_range(0, 31)));
        checkOutput("b.psel", 64'(controlword[30:29]), 64'd2);
        checkOutput("b.k", k, 64'hFFFF_FFFF_FFFF_FFE4);

        // MOVZ X9, #1200 with hw = 0 and hw = 1
        applyStimulus(movz0Ins, 5'd0);
        applyStimulus($urandom, 5'd0);
        checkOutput("movz0.k", k, 64'd1200);
        checkOutput("movz0.enb_bsel_regw", 64'({controlword[4], controlword[2], controlword[8]}), 64'b111);
        applyStimulus(movz1Ins, 5'd0);
        applyStimulus($urandom, 5'd0);
        checkOutput("movz1.k", k, 64'd78643200);
        checkOutput("movz1.enb_bsel_regw", 64'({controlword[4], controlword[2], controlword[8]}), 64'b111);

        // Reset in the middle of LDUR EX0, then an all-zero (illegal) word
        applyStimulus(ldurIns, 5'd0);
        applyStimulus($urandom, 5'd0);
        doReset(32'h0000_0000);
        applyStimulus($urandom, 5'd0);
        checkOutput("illegal_ex0.controlword", 64'(controlword), 64'h2000_0000);
        checkOutput("illegal_ex0.k", k, 64'd0);
        checkOutput("illegal_ex0.flag", 64'(illegal), 64'd0);
        applyStimulus(addiIns, 5'd0);
        checkOutput("illegal_after.flag", 64'(illegal), 64'd1);
        applyStimulus($urandom, 5'd0);
        checkOutput("illegal_sticky.flag", 64'(illegal), 64'd1);

        // Randomized run with occasional resets
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(randInstr(), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 399) == 0) doReset(randInstr());
        end

        doReset(32'h0000_0000);
        checkOutput("final_reset.illegal", 64'(illegal), 64'd0);
        @(negedge clock);
        checkEnable = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multicycle control unit for the LEGv8 datapath; produces the 32-bit control word that the datapath splits into fields, plus the immediate K.
- Latches the instruction from the instruction ROM and decodes it.
- Sequences each instruction through FETCH / EX0 / EX1 and drives PC update selects.
- Uses datapath status flags to resolve conditional branches.

Parameters:
- XLEN, 64, width of K.
- LINK_REG, 30, destination register for BL.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- instruction  input  32  ROM output addressed by PC.
- status  input  5  [3:0]={V,C,N,Z} live ALU flags; [4]=registered Z.
- ir_load  output  1  high in FETCH; IR captures instruction at that edge.
- controlword  output  32  [31]=0, [30:29]Psel, [28:24]DA, [23:19]SA, [18:14]SB, [13:9]Fsel, [8]regW, [7]ramW, [6]EN_MEM, [5]EN_ALU, [4]EN_B, [3]EN_PC, [2]Bsel, [1]PCsel, [0]SL.
- K  output  XLEN  decoded immediate.
- illegal  output  1  sticky flag for an undecodable opcode.

Behaviour:
- Reset (async, reset_n=0): state=FETCH, IR=0, illegal=0; controlword=0, K=0, ir_load=0 while reset is asserted. Reset mid-instruction abandons it; nothing is written.
- Psel encoding: 00 hold PC; 01 PC+4; 10 PC+K; 11 PC=bus (PCsel=1).
- Fsel encoding: AND=00000, ORR=00100, ADD=01000, SUB=01001.
- The PC is updated only in the last execute state, so branches are relative to the branch instruction's own address.
- FETCH: controlword=0, ir_load=1; next state is EX0.
- R-type ADD/SUB/AND/ORR/ADDS/SUBS:
  - EX0 drives SA=Rn, SB=Rm, DA=Rd, Fsel, EN_ALU, regW, Psel=01.
  - SL=1 only for ADDS/SUBS.
  - Next state is FETCH.
- ADDI/SUBI:
  - EX0 drives SA=Rn, DA=Rd, Bsel=1, Fsel=ADD/SUB, EN_ALU, regW, Psel=01.
  - K=zero-extended imm12.
- MOVZ:
  - EX0 drives DA=Rd, Bsel=1, EN_B, regW, Psel=01.
  - K=imm16<<(16*hw); hw in [22:21].
- LDUR (3 cycles):
  - EX0 drives SA=Rn, Bsel=1, Fsel=ADD, Psel=00, no enables. This presents the RAM address.
  - EX1 holds the same SA/Bsel/Fsel and adds EN_MEM, regW, DA=Rt, Psel=01.
  - K=sign-extended addr9.
- STUR:
  - EX0 drives SA=Rn, SB=Rt, Bsel=1, Fsel=ADD, ramW, Psel=01.
  - Store data is the register B port before the Bsel mux.
- CBZ/CBNZ:
  - EX0 drives SA=Rt, SB=31, Bsel=0, Fsel=ADD.
  - Psel=10 if status[0]==1 (CBZ) or ==0 (CBNZ); otherwise Psel=01. This is combinational on live status.
  - K=sign-extended addr19<<2.
- B:
  - EX0 drives Psel=10.
  - K=sign-extended addr26<<2.
- BL (3 cycles):
  - EX0 drives DA=LINK_REG, EN_PC, regW, Psel=00.
  - EX1 drives Psel=10, with K the same as for B.
- BR:
  - EX0 drives SA=Rn, SB=31, Fsel=ORR, EN_ALU, PCsel=1, Psel=11.
- Opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDS 10101011000, SUBS 11101011000, ADDI 1001000100, SUBI 1101000100, MOVZ 110100101, LDUR 11111000010, STUR 11111000000, CBZ 10110100, CBNZ 10110101, B 000101, BL 100101, BR 11010110000.
- Decode priority is longest opcode first.
- Any other opcode (including 0x00000000):
  - EX0 drives controlword with only Psel=01 (skip); K=0.
  - illegal is set and stays set until reset.
- DA=31 writes are still issued; the register file discards them.
- K holds its decoded value for every state after FETCH; it is 0 in FETCH.

Test Plan:
- ADDI X4,XZR,100 (0x910193E4) -> FETCH then EX0 shows Psel=01, DA=4, SA=31, Bsel=1, Fsel=01000, EN_ALU=1, regW=1, K=100; FETCH again on cycle 3.
- LDUR X10,[X8,0] -> EX0 shows SA=8, Bsel=1, Psel=00, regW=0; EX1 shows EN_MEM=1, regW=1, DA=10, Psel=01; instruction takes 3 cycles.
- CBZ X4,6 -> with status[0]=1, Psel=10 and K=24; repeated with status[0]=0, Psel=01 and K=24.
- B -7 (0x17FFFFF9) -> Psel=10, K=64'hFFFFFFFFFFFFFFE4.
- MOVZ X9,1200 with hw=0 -> K=1200; with hw=1 -> K=78643200; EN_B=1, Bsel=1, regW=1 in both.
- Reset_n pulsed low during LDUR EX0 -> controlword=0 and ir_load=0 immediately; FETCH follows release. Then instruction 0x00000000 -> illegal=1 after EX0 with Psel=01, and illegal stays set until the next reset.
